// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the store-and-forward packet FIFO.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} wr_state_e;

  localparam int DROP_CNT_W = 32;

  // One extra MSB lets full and empty be told apart after a wrap.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sc_ram_1r1w.sv
// Single-clock 1R1W RAM, registered read; a read of the address being written returns old data.
module sc_ram_1r1w #(
  parameter int DEPTH = 512,
  parameter int W     = 520
) (
  input  logic                     in_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  // rd_data holds its value while rd_en is low; the FIFO relies on that as a stall stage.
  always_ff @(posedge in_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pkt_fifo_sf.sv
// Avalon-ST packet FIFO with store-and-forward/cut-through, drop-on-full rewind,
// almost_full hysteresis, committed packet count and saturating drop counter.
module pkt_fifo_sf
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W       = 512,
  parameter int EMPTY_W      = 6,
  parameter int DEPTH        = 512,
  parameter int STORE_FWD    = 1,
  parameter int DROP_ON_FULL = 0,
  parameter int AF_HIGH      = 450,
  parameter int AF_LOW       = 400,
  localparam int PW          = ptr_w(DEPTH)
) (
  input  logic                  in_clk,
  input  logic                  rst_l,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [EMPTY_W-1:0]    in_empty,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [EMPTY_W-1:0]    out_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW-1:0]         fill_level,
  output logic [PW-1:0]         pkt_count,
  output logic                  almost_full,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int AW = PW - 1;
  localparam int RW = DATA_W + EMPTY_W + 2;

  wr_state_e     st, st_nxt;
  logic [PW-1:0] wr_work, wr_commit, rd_fetch, rd, wr_base, lim;
  logic          full, acc, pop, adv, fetch, s1_vld;
  logic          wr_en, commit, rewind, drop_inc;
  logic [RW-1:0] ram_q;

  assign fill_level = wr_work - rd;
  assign full       = fill_level == PW'(DEPTH);
  assign in_ready   = (DROP_ON_FULL != 0) ? 1'b1 : !full;
  assign acc        = in_valid & in_ready;

  // Write-side decode: what the accepted beat does to the pointers and counters.
  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    drop_inc = 1'b0;
    st_nxt   = st;
    if (acc) begin
      if (DROP_ON_FULL != 0 && full && st != DROP) begin
        rewind   = 1'b1;
        drop_inc = 1'b1;
        st_nxt   = in_eop ? IDLE : DROP;
      end else begin
        case (st)
          IDLE: begin
            if (in_sop) begin
              wr_en = 1'b1;
              if (in_eop) commit = 1'b1;
              else        st_nxt = IN_PKT;
            end else begin
              drop_inc = 1'b1;
            end
          end
          IN_PKT: begin
            wr_en = 1'b1;
            if (in_sop) begin
              drop_inc = 1'b1;
              rewind   = (STORE_FWD != 0);
            end
            if (in_eop) begin
              commit = 1'b1;
              st_nxt = IDLE;
            end
          end
          DROP: if (in_eop) st_nxt = IDLE;
          default: ;
        endcase
      end
    end
  end

  assign wr_base = rewind ? wr_commit : wr_work;

  always_ff @(posedge in_clk or negedge rst_l) begin
    if (!rst_l) begin
      st         <= IDLE;
      wr_work    <= '0;
      wr_commit  <= '0;
      drop_count <= '0;
    end else begin
      st      <= st_nxt;
      wr_work <= wr_base + PW'(wr_en);
      if (commit) wr_commit <= wr_base + PW'(1);
      if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  // Read side: RAM output register is stage 1, out_* is stage 2.
  assign lim   = (STORE_FWD != 0) ? wr_commit : wr_work;
  assign pop   = out_valid & out_ready;
  assign adv   = s1_vld & (!out_valid | out_ready);
  assign fetch = (rd_fetch != lim) & (!s1_vld | adv);

  sc_ram_1r1w #(.DEPTH(DEPTH), .W(RW)) u_ram (
    .in_clk  (in_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_base[AW-1:0]),
    .wr_data ({in_sop, in_eop, in_empty, in_data}),
    .rd_en   (fetch),
    .rd_addr (rd_fetch[AW-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge in_clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_fetch    <= '0;
      rd          <= '0;
      s1_vld      <= 1'b0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
      out_data    <= '0;
      pkt_count   <= '0;
      almost_full <= 1'b0;
    end else begin
      rd_fetch  <= rd_fetch + PW'(fetch);
      rd        <= rd + PW'(pop);
      s1_vld    <= fetch | (s1_vld & !adv);
      out_valid <= adv | (out_valid & !out_ready);
      if (adv) {out_sop, out_eop, out_empty, out_data} <= ram_q;
      pkt_count <= pkt_count + PW'(commit) - PW'(pop & out_eop);
      if (fill_level >= PW'(AF_HIGH))    almost_full <= 1'b1;
      else if (fill_level < PW'(AF_LOW)) almost_full <= 1'b0;
    end
  end

  if (DROP_ON_FULL != 0 && STORE_FWD == 0) begin : g_bad_drop
    $fatal(1, "pkt_fifo_sf: DROP_ON_FULL requires STORE_FWD");
  end
  if (AF_LOW > AF_HIGH) begin : g_bad_af
    $fatal(1, "pkt_fifo_sf: AF_LOW must not exceed AF_HIGH");
  end

  // A store-and-forward packet that alone fills the FIFO can never commit.
  assert property (@(posedge in_clk) disable iff (!rst_l)
    !(STORE_FWD != 0 && DROP_ON_FULL == 0 && st == IN_PKT && full && wr_commit == rd))
    else $error("pkt_fifo_sf: packet longer than DEPTH in store-and-forward mode");

endmodule

// File: tb/tb_pkt_fifo_sf.sv
// Bench for pkt_fifo_sf: three DEPTH=8 instances (store-fwd, cut-through, drop-on-full)
// checked every cycle against a packet-level reference model.
module tb_pkt_fifo_sf;
  localparam int DW = 32, EW = 2, N = 3, D = 8;

  typedef struct packed {logic sop; logic eop; logic [EW-1:0] emp; logic [DW-1:0] d;} beat_t;

  logic clk = 0, rst_l = 0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data;
  logic          in_sop, in_eop;
  logic [EW-1:0] in_empty;
  logic          in_valid [N], in_ready [N], out_valid [N], out_ready [N];
  logic          out_sop [N], out_eop [N], almost_full [N];
  logic [DW-1:0] out_data [N];
  logic [EW-1:0] out_empty [N];
  logic [3:0]    fill_level [N], pkt_count [N];
  logic [31:0]   drop_count [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    pkt_fifo_sf #(.DATA_W(DW), .EMPTY_W(EW), .DEPTH(D), .STORE_FWD(g == 1 ? 0 : 1),
                  .DROP_ON_FULL(g == 2 ? 1 : 0), .AF_HIGH(6), .AF_LOW(3)) u_dut (
      .in_clk(clk), .rst_l(rst_l), .in_data(in_data), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .out_data(out_data[g]),
      .out_sop(out_sop[g]), .out_eop(out_eop[g]), .out_empty(out_empty[g]), .out_valid(out_valid[g]),
      .out_ready(out_ready[g]), .fill_level(fill_level[g]), .pkt_count(pkt_count[g]),
      .almost_full(almost_full[g]), .drop_count(drop_count[g]));
  end

  // Reference model: beats held per open packet, beats expected at the output, occupancy.
  beat_t expq [N][$];
  beat_t pend [N][$];
  int    occ [N], drops [N], pkts [N];
  bit    inpkt [N], dropping [N], maf [N], last_acc [N], last_pop [N], rr [N];
  logic [15:0] vmask [N];
  int    checks = 0, fails = 0, cyc_cnt = 0, t0 = 0;

  function automatic bit sf(int i);  return i != 1; endfunction
  function automatic bit dof(int i); return i == 2; endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      expq[i].delete(); pend[i].delete();
      occ[i] = 0; drops[i] = 0; pkts[i] = 0;
      inpkt[i] = 0; dropping[i] = 0; maf[i] = 0;
    end
  endtask

  task automatic accept(int i, beat_t b);
    if (dropping[i]) begin
      if (b.eop) dropping[i] = 0;
      return;
    end
    if (dof(i) && occ[i] == D) begin
      occ[i] -= pend[i].size(); pend[i].delete();
      drops[i]++; inpkt[i] = 0; dropping[i] = !b.eop;
      return;
    end
    if (!inpkt[i]) begin
      if (!b.sop) begin drops[i]++; return; end
    end else if (b.sop) begin
      drops[i]++;
      if (sf(i)) begin occ[i] -= pend[i].size(); pend[i].delete(); end
    end
    occ[i]++;
    if (sf(i)) pend[i].push_back(b); else expq[i].push_back(b);
    if (b.eop) begin
      pkts[i]++; inpkt[i] = 0;
      if (sf(i)) begin
        for (int k = 0; k < pend[i].size(); k++) expq[i].push_back(pend[i][k]);
        pend[i].delete();
      end
    end else inpkt[i] = 1;
  endtask

  task automatic tick();
    beat_t ib, ob, eb;
    int k;
    @(negedge clk);
    ib = {in_sop, in_eop, in_empty, in_data};
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fill_level[%0d]", i), fill_level[i], occ[i]);
      chk($sformatf("pkt_count[%0d]", i), pkt_count[i], pkts[i]);
      chk($sformatf("drop_count[%0d]", i), drop_count[i], drops[i]);
      chk($sformatf("almost_full[%0d]", i), almost_full[i], maf[i]);
      k = cyc_cnt - t0 - 1;
      if (out_valid[i] && k >= 0 && k < 16) vmask[i][k] = 1'b1;
      last_acc[i] = in_valid[i] && in_ready[i];
      last_pop[i] = out_valid[i] && out_ready[i];
      maf[i] = occ[i] >= 6 ? 1'b1 : (occ[i] < 3 ? 1'b0 : maf[i]);
      if (last_acc[i]) accept(i, ib);
      if (last_pop[i]) begin
        ob = {out_sop[i], out_eop[i], out_empty[i], out_data[i]};
        chk($sformatf("pop_expected[%0d]", i), expq[i].size() > 0, 1);
        if (expq[i].size() > 0) begin
          eb = expq[i].pop_front();
          chk($sformatf("beat[%0d]", i), ob, eb);
        end
        occ[i]--;
        if (ob.eop) pkts[i]--;
      end
    end
    @(posedge clk); cyc_cnt++; #1;
    for (int i = 0; i < N; i++) if (rr[i]) out_ready[i] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(int i, bit sop, bit eop, logic [DW-1:0] d, int lim, bit want);
    int n = 0;
    in_valid[i] = 1; in_sop = sop; in_eop = eop; in_data = d; in_empty = EW'(d);
    do begin tick(); n++; end while (!last_acc[i] && n < lim);
    in_valid[i] = 0;
    chk($sformatf("accept[%0d]", i), last_acc[i], want);
  endtask

  task automatic send_pkt(int i, int len, logic [DW-1:0] base);
    for (int k = 0; k < len; k++) push(i, k == 0, k == len - 1, base + DW'(k), 50, 1);
  endtask

  task automatic drain(int i, int lim);
    int n = 0;
    rr[i] = 0; out_ready[i] = 1;
    while ((expq[i].size() != 0 || out_valid[i]) && n < lim) begin tick(); n++; end
    chk($sformatf("drain[%0d]", i), expq[i].size(), 0);
  endtask

  task automatic pop_n(int i, int n);
    int got = 0, t = 0;
    out_ready[i] = 1;
    while (got < n && t < 50) begin tick(); t++; if (last_pop[i]) got++; end
    out_ready[i] = 0;
    chk($sformatf("pop_n[%0d]", i), got, n);
  endtask

  initial begin
    in_data = '0; in_sop = 0; in_eop = 0; in_empty = '0;
    for (int i = 0; i < N; i++) begin in_valid[i] = 0; out_ready[i] = 0; rr[i] = 0; vmask[i] = '0; end
    model_reset();
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
      chk($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
    end
    rst_l = 1;
    tick();

    // Latency, store-and-forward then cut-through.
    for (int i = 0; i < 2; i++) begin
      out_ready[i] = 1; t0 = cyc_cnt; vmask[i] = '0;
      push(i, 1, 0, 32'hA0 + i, 5, 1);
      push(i, 0, 0, 32'hB1 + i, 5, 1);
      push(i, 0, 1, 32'hC2 + i, 5, 1);
      repeat (6) tick();
      chk($sformatf("valid_window[%0d]", i), vmask[i], i == 0 ? 16'h0070 : 16'h001C);
      chk($sformatf("empty_after[%0d]", i), fill_level[i], 0);
    end

    // Fill to full with output stalled, then two wrap-around fills.
    out_ready[0] = 0;
    for (int k = 0; k < 8; k++) push(0, 1, 1, 32'h100 + k, 5, 1);
    push(0, 1, 1, 32'h108, 4, 0);
    chk("full_in_ready", in_ready[0], 0);
    chk("full_fill", fill_level[0], 8);
    out_ready[0] = 1;
    push(0, 1, 1, 32'h108, 20, 1);
    push(0, 1, 1, 32'h109, 20, 1);
    drain(0, 40);
    out_ready[0] = 0;
    for (int k = 0; k < 8; k++) push(0, 1, 1, 32'h200 + k, 5, 1);
    chk("refill_fill", fill_level[0], 8);
    drain(0, 40);

    // Drop-on-full: second packet overflows and is rewound.
    out_ready[2] = 0;
    send_pkt(2, 6, 32'h300);
    send_pkt(2, 5, 32'h400);
    tick();
    chk("dof_drop_count", drop_count[2], 1);
    chk("dof_fill", fill_level[2], 6);
    drain(2, 40);

    // sop, beat, sop, eop: fragment discarded.
    push(0, 1, 0, 32'h500, 5, 1);
    push(0, 0, 0, 32'h501, 5, 1);
    push(0, 1, 0, 32'h502, 5, 1);
    push(0, 0, 1, 32'h503, 5, 1);
    chk("frag_drop_count", drop_count[0], 1);
    drain(0, 40);

    // almost_full hysteresis 6/3.
    out_ready[0] = 0;
    for (int k = 0; k < 6; k++) push(0, 1, 1, 32'h600 + k, 5, 1);
    tick();
    chk("af_set", almost_full[0], 1);
    pop_n(0, 2); tick();
    chk("af_hold_fill", fill_level[0], 4);
    chk("af_hold", almost_full[0], 1);
    pop_n(0, 2); tick();
    chk("af_clear", almost_full[0], 0);
    drain(0, 40);

    // Random packets, including strays and truncations, per instance.
    for (int i = 0; i < N; i++) begin
      rr[i] = 1;
      for (int p = 0; p < 30; p++) begin
        int len, r;
        len = $urandom_range(1, i == 2 ? 7 : 5);
        r = $urandom_range(0, 9);
        if (r == 0) push(i, 0, 0, $urandom, 50, 1);
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(0, 3) == 0) tick();
          push(i, k == 0, (k == len - 1) && r != 1, $urandom, 50, 1);
        end
      end
      drain(i, 200);
    end

    // Asynchronous reset in the middle of a packet.
    out_ready[0] = 0;
    push(0, 1, 1, 32'h700, 20, 1);
    push(0, 1, 0, 32'h701, 20, 1);
    repeat (3) tick();
    rst_l = 0; #1;
    chk("arst_out_valid", out_valid[0], 0);
    chk("arst_fill", fill_level[0], 0);
    chk("arst_pkt", pkt_count[0], 0);
    chk("arst_af", almost_full[0], 0);
    chk("arst_drop", drop_count[0], 0);
    chk("arst_in_ready", in_ready[0], 1);
    model_reset();
    repeat (2) tick();
    rst_l = 1;
    send_pkt(0, 2, 32'h800);
    drain(0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
